// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at its midpoint,
// and reports each byte with a one-cycle valid or framing-error pulse.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_RxD,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    // Synchronizer resets to all ones so the line looks idle out of reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_RxD};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // o_Busy is registered alongside every state change so it tracks state != IDLE.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_Data      <= '0;
            o_Valid     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            o_Valid     <= 1'b0;
            o_Frame_Err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt    <= '0;
                        state  <= S_START;
                        o_Busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_MAX) begin
                        if (!rx_s) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state  <= S_IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_MAX) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_MAX) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_Data  <= shreg;
                            o_Valid <= 1'b1;
                            state   <= S_IDLE;
                            o_Busy  <= 1'b0;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    // Held-low line must not look like a new start bit.
                    if (rx_s) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: drives serial frames bit by bit and checks
// received bytes, pulse counts and busy behaviour against hand-computed values.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int check_count = 0;
    int error_count = 0;
    int cycle_count = 0;
    int valid_count = 0;
    int ferr_count  = 0;
    logic [7:0] rx_hist[$];
    int         rx_cycle[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_RxD      (rxd),
        .o_Data     (data),
        .o_Valid    (valid),
        .o_Frame_Err(frame_err),
        .o_Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count++;

    // Pulse monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_count++;
            rx_hist.push_back(data);
            rx_cycle.push_back(cycle_count);
        end
        if (frame_err) ferr_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Sends start, 8 data bits LSB first, then the given stop level; starts at a negedge.
    task automatic applyStimulus(input logic [7:0] byte_val, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = byte_val[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int v0;
        int f0;
        int n0;
        logic [7:0] c3;

        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_ferr", 32'(frame_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_no_valid", 32'(valid_count), 32'd0);

        // Single frame 0xA5
        v0 = valid_count;
        n0 = rx_hist.size();
        applyStimulus(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("a5_pulses", 32'(valid_count - v0), 32'd1);
        if (rx_hist.size() > n0) checkOutput("a5_data", 32'(rx_hist[n0]), 32'hA5);
        else checkOutput("a5_data_missing", 32'(rx_hist.size()), 32'(n0 + 1));
        checkOutput("a5_hold", 32'(data), 32'hA5);
        checkOutput("a5_no_ferr", 32'(ferr_count), 32'd0);

        // Back-to-back 0x00 then 0xFF
        v0 = valid_count;
        n0 = rx_hist.size();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("b2b_pulses", 32'(valid_count - v0), 32'd2);
        if (rx_hist.size() >= n0 + 2) begin
            checkOutput("b2b_first", 32'(rx_hist[n0]), 32'h00);
            checkOutput("b2b_second", 32'(rx_hist[n0+1]), 32'hFF);
            checkOutput("b2b_spacing", 32'(rx_cycle[n0+1] - rx_cycle[n0]), 32'd160);
        end else begin
            checkOutput("b2b_missing", 32'(rx_hist.size()), 32'(n0 + 2));
        end

        // Glitch: 4 cycles low
        v0 = valid_count;
        f0 = ferr_count;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitch_busy_seen", 32'(busy), 32'h1);
        rxd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput("glitch_busy_low", 32'(busy), 32'h0);
        repeat (30) @(negedge clk);
        checkOutput("glitch_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("glitch_no_ferr", 32'(ferr_count - f0), 32'd0);

        // Framing error on 0x3C, line held low afterwards
        v0 = valid_count;
        f0 = ferr_count;
        applyStimulus(8'h3C, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("ferr_pulses", 32'(ferr_count - f0), 32'd1);
        checkOutput("ferr_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("ferr_data_kept", 32'(data), 32'hFF);
        checkOutput("ferr_busy_held", 32'(busy), 32'h1);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("ferr_busy_release", 32'(busy), 32'h0);
        applyStimulus(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("after_ferr_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("after_ferr_data", 32'(data), 32'h5A);

        // Reset asserted halfway through bit 4 of 0xC3
        c3 = 8'hC3;
        v0 = valid_count;
        f0 = ferr_count;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = c3[4];
        repeat (CPB / 2) @(negedge clk);
        checkOutput("midframe_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_data", 32'(data), 32'h00);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_no_pulse", 32'(valid_count - v0), 32'd0);
        applyStimulus(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("c3_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("c3_data", 32'(data), 32'hC3);
        checkOutput("c3_no_ferr", 32'(ferr_count - f0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
